// File: rtl/toysram_scan_array.sv
// toysram_scan_array: 32x32 flop array reached from chip pins through a 128-bit scan register.
// Pin strobes are synchronised into clock and acted on at their synchronised rising edge.
`timescale 1ns/1ps
module toysram_scan_array #(
  parameter int SCAN_W = 128,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int SYNC_N = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic te,
  input  logic scan_clk,
  input  logic scan_in,
  output logic scan_out,
  input  logic ra0_clk,
  input  logic ra0_rst,
  input  logic ra0_r0_en,
  input  logic ra0_r1_en,
  input  logic ra0_w0_en
);
  localparam int NPIN   = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int R0_ADR = SCAN_W - 1;
  localparam int R0_DAT = R0_ADR - ADDR_W;
  localparam int R1_ADR = R0_DAT - DATA_W;
  localparam int R1_DAT = R1_ADR - ADDR_W;
  localparam int W0_ADR = R1_DAT - DATA_W;
  localparam int W0_DAT = W0_ADR - ADDR_W;

  logic [NPIN-1:0]   pins;
  logic [NPIN-1:0]   sync_q [SYNC_N];
  logic              te_s, scan_clk_s, scan_in_s, ra0_clk_s, ra0_rst_s;
  logic              r0_en_s, r1_en_s, w0_en_s;
  logic              scan_clk_d, ra0_clk_d;
  logic              scan_rise, ra0_step;

  logic [SCAN_W-1:0] scan_reg, scan_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              r0_en_q, r1_en_q, w0_en_q;
  logic [ADDR_W-1:0] r0_adr_q, r1_adr_q, w0_adr_q;
  logic [DATA_W-1:0] w0_dat_q;

  assign pins = {te, scan_clk, scan_in, ra0_clk, ra0_rst, ra0_r0_en, ra0_r1_en, ra0_w0_en};
  assign {te_s, scan_clk_s, scan_in_s, ra0_clk_s, ra0_rst_s, r0_en_s, r1_en_s, w0_en_s} =
    sync_q[SYNC_N-1];

  // Synchroniser chain and edge-detect history
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < SYNC_N; i++) sync_q[i] <= '0;
      scan_clk_d <= 1'b0;
      ra0_clk_d  <= 1'b0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
      scan_clk_d <= scan_clk_s;
      ra0_clk_d  <= ra0_clk_s;
    end
  end

  assign scan_rise = scan_clk_s & ~scan_clk_d;
  assign ra0_step  = ra0_clk_s & ~ra0_clk_d & ~ra0_rst_s;

  // Shift first, then read data lands on its fields; reads see pre-write memory
  always_comb begin
    scan_nxt = scan_reg;
    if (te_s && scan_rise) scan_nxt = {scan_reg[SCAN_W-2:0], scan_in_s};
    if (ra0_step && r0_en_q) scan_nxt[R0_DAT -: DATA_W] = mem[r0_adr_q];
    if (ra0_step && r1_en_q) scan_nxt[R1_DAT -: DATA_W] = mem[r1_adr_q];
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) scan_reg <= '0;
    else         scan_reg <= scan_nxt;
  end

  assign scan_out = scan_reg[SCAN_W-1];

  // Array step: execute the held command, then capture the next from pre-shift scan_reg
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ra0_rst_s) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ra0_step && w0_en_q) begin
      mem[w0_adr_q] <= w0_dat_q;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r0_en_q  <= 1'b0;
      r1_en_q  <= 1'b0;
      w0_en_q  <= 1'b0;
      r0_adr_q <= '0;
      r1_adr_q <= '0;
      w0_adr_q <= '0;
      w0_dat_q <= '0;
    end else if (ra0_rst_s) begin
      r0_en_q  <= 1'b0;
      r1_en_q  <= 1'b0;
      w0_en_q  <= 1'b0;
      r0_adr_q <= '0;
      r1_adr_q <= '0;
      w0_adr_q <= '0;
      w0_dat_q <= '0;
    end else if (ra0_step) begin
      r0_en_q  <= r0_en_s;
      r1_en_q  <= r1_en_s;
      w0_en_q  <= w0_en_s;
      r0_adr_q <= scan_reg[R0_ADR -: ADDR_W];
      r1_adr_q <= scan_reg[R1_ADR -: ADDR_W];
      w0_adr_q <= scan_reg[W0_ADR -: ADDR_W];
      w0_dat_q <= scan_reg[W0_DAT -: DATA_W];
    end
  end

endmodule

// File: tb/tb_toysram_scan_array.sv
// Bench for toysram_scan_array: scan images are queued as expectations when the
// stimulus that produces them is driven, and compared as they are scanned out.
`timescale 1ns/1ps
module tb_toysram_scan_array;
  logic clock = 1'b0;
  logic resetb = 1'b0;
  logic te = 1'b0, scan_clk = 1'b0, scan_in = 1'b0;
  logic scan_out;
  logic ra0_clk = 1'b0, ra0_rst = 1'b0;
  logic ra0_r0_en = 1'b0, ra0_r1_en = 1'b0, ra0_w0_en = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q [$];

  toysram_scan_array dut (
    .clock    (clock),
    .resetb   (resetb),
    .te       (te),
    .scan_clk (scan_clk),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .ra0_clk  (ra0_clk),
    .ra0_rst  (ra0_rst),
    .ra0_r0_en(ra0_r0_en),
    .ra0_r1_en(ra0_r1_en),
    .ra0_w0_en(ra0_w0_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    bit           rst_first;
    bit           do_scan;
    logic [127:0] cmd;
    logic [2:0]   en;
    logic [127:0] exp;
  } step_t;

  function automatic logic [127:0] cmd(input logic [4:0] r0a, input logic [31:0] r0d,
                                       input logic [4:0] r1a, input logic [31:0] r1d,
                                       input logic [4:0] w0a, input logic [31:0] w0d,
                                       input logic [16:0] pad);
    return {r0a, r0d, r1a, r1d, w0a, w0d, pad};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_scan(input logic b);
    scan_in = b;
    tick(1);
    scan_clk = 1'b1;
    tick(4);
    scan_clk = 1'b0;
    tick(4);
  endtask

  // Shift v in MSB-first while capturing the previous contents from scan_out
  task automatic scan_xfer(input string name, input logic [127:0] v);
    logic [127:0] got;
    logic [127:0] want;
    got = '0;
    for (int i = 127; i >= 0; i--) begin
      got[i] = scan_out;
      pulse_scan(v[i]);
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h want <no queued image>", name, got);
    end else begin
      want = exp_q.pop_front();
      check(name, got, want);
    end
  endtask

  task automatic ra0_pulse(input logic [2:0] en);
    {ra0_r0_en, ra0_r1_en, ra0_w0_en} = en;
    tick(1);
    ra0_clk = 1'b1;
    tick(4);
    ra0_clk = 1'b0;
    tick(4);
  endtask

  task automatic ra0_reset_pulse();
    ra0_rst = 1'b1;
    tick(5);
    ra0_rst = 1'b0;
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [127:0] v, w, ones, c3, c5, c6a, c6;
    step_t steps [14];

    v    = 128'h0123456789ABCDEFFEDCBA9876543210;
    w    = {~v[0], ~v[127:1]};
    ones = '1;
    c3   = cmd(5'h00, 32'hFFFFFFFF, 5'h01, 32'hFFFFFFFF, 5'h00, 32'h08675309, 17'h1BABE);
    c5   = cmd(5'h01, 32'h11111111, 5'h01, 32'h22222222, 5'h01, 32'hDEADBEEF, 17'h0AAAA);
    c6a  = cmd(5'h03, 32'h0, 5'h03, 32'h0, 5'h03, 32'h12345678, 17'h0);
    c6   = cmd(5'h03, 32'h0, 5'h03, 32'h0, 5'h03, 32'hCAFEF00D, 17'h0);

    // en = {r0, r1, w0}; exp = image held after this step's array strobe
    steps[0]  = '{"t3_cap",      1'b1, 1'b1, c3,  3'b111, c3};
    steps[1]  = '{"t3_exec",     1'b0, 1'b0, c3,  3'b111,
                  cmd(5'h00, 32'h0, 5'h01, 32'h0, 5'h00, 32'h08675309, 17'h1BABE)};
    steps[2]  = '{"t4_rd",       1'b0, 1'b1, c3,  3'b110,
                  cmd(5'h00, 32'h08675309, 5'h01, 32'h0, 5'h00, 32'h08675309, 17'h1BABE)};
    steps[3]  = '{"t4_rd_again", 1'b0, 1'b1, c3,  3'b110,
                  cmd(5'h00, 32'h08675309, 5'h01, 32'h0, 5'h00, 32'h08675309, 17'h1BABE)};
    steps[4]  = '{"t5_wcap",     1'b0, 1'b1, c5,  3'b001, c5};
    steps[5]  = '{"t5_wexec",    1'b0, 1'b0, c5,  3'b100, c5};
    steps[6]  = '{"t5_rd1",      1'b0, 1'b0, c5,  3'b000,
                  cmd(5'h01, 32'hDEADBEEF, 5'h01, 32'h0, 5'h01, 32'hDEADBEEF, 17'h0AAAA)};
    steps[7]  = '{"t5_rst_cap",  1'b1, 1'b1, c5,  3'b100, c5};
    steps[8]  = '{"t5_rst_rd",   1'b0, 1'b0, c5,  3'b000,
                  cmd(5'h01, 32'h0, 5'h01, 32'h22222222, 5'h01, 32'hDEADBEEF, 17'h0AAAA)};
    steps[9]  = '{"t6_pre_cap",  1'b0, 1'b1, c6a, 3'b001, c6a};
    steps[10] = '{"t6_pre_wr",   1'b0, 1'b0, c6a, 3'b000, c6a};
    steps[11] = '{"t6_col_cap",  1'b0, 1'b1, c6,  3'b111, c6};
    steps[12] = '{"t6_col",      1'b0, 1'b0, c6,  3'b110,
                  cmd(5'h03, 32'h12345678, 5'h03, 32'h12345678, 5'h03, 32'hCAFEF00D, 17'h0)};
    steps[13] = '{"t6_new",      1'b0, 1'b1, c6,  3'b000,
                  cmd(5'h03, 32'hCAFEF00D, 5'h03, 32'hCAFEF00D, 5'h03, 32'hCAFEF00D, 17'h0)};

    tick(3);
    check("reset_scan_out", {127'b0, scan_out}, 128'h0);
    resetb = 1'b1;
    tick(3);
    te = 1'b1;
    tick(4);

    exp_q.push_back(128'h0);
    scan_xfer("t1_reset_image", v);
    exp_q.push_back(v);
    scan_xfer("t1_readback", w);

    te = 1'b0;
    tick(4);
    for (int i = 0; i < 6; i++) pulse_scan(i[0]);
    te = 1'b1;
    tick(4);
    exp_q.push_back(w);
    scan_xfer("t2_te_off_hold", 128'h0);

    exp_q.push_back(128'h0);
    for (int i = 0; i < 14; i++) begin
      if (steps[i].rst_first) ra0_reset_pulse();
      if (steps[i].do_scan) scan_xfer({"pre_", steps[i].name}, steps[i].cmd);
      ra0_pulse(steps[i].en);
      if (i == 13 || steps[(i + 1) % 14].do_scan) exp_q.push_back(steps[i].exp);
    end
    scan_xfer("t6_final", ones);

    for (int i = 0; i < 20; i++) pulse_scan(v[127 - i]);
    resetb = 1'b0;
    #1;
    check("t5_resetb_scan_out", {127'b0, scan_out}, 128'h0);
    tick(3);
    resetb = 1'b1;
    tick(4);
    exp_q.push_back(128'h0);
    scan_xfer("t5_post_reset_clean", v);
    exp_q.push_back(v);
    scan_xfer("t5_post_reset_readback", c6);
    ra0_pulse(3'b110);
    ra0_pulse(3'b000);
    exp_q.push_back(cmd(5'h03, 32'h0, 5'h03, 32'h0, 5'h03, 32'hCAFEF00D, 17'h0));
    scan_xfer("t5_post_reset_mem", 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
